// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage of the 5-stage MIPS pipeline.
// Decodes ALUop/funct, runs the 32-bit ALU on reg_data1 and the operand-B
// mux, and computes the branch target. All outputs are registered into the
// EX/MEM boundary with one cycle of latency.
// Optional feature macro: ALU_OVERFLOW_EN adds a registered signed-overflow
// output for ADD/SUB. Without it, the port and its logic are removed.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  alu_op,
    input  logic        alu_src,
    input  logic [31:0] reg_data1,
    input  logic [31:0] reg_data2,
    input  logic [31:0] sign_ext_imm,
    input  logic [31:0] incremented_pc,
    output logic [31:0] alu_result,
    output logic        zero_flag,
`ifdef ALU_OVERFLOW_EN
    output logic        overflow,
`endif
    output logic [31:0] branch_address
);

    typedef enum logic [2:0] {
        CTL_ADD,
        CTL_SUB,
        CTL_AND,
        CTL_OR,
        CTL_NOR,
        CTL_SLT,
        CTL_SLL,
        CTL_SRL
    } alu_ctl_t;

    alu_ctl_t    alu_ctl;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] operand_b;
    logic [31:0] add_sum;
    logic [31:0] sub_diff;
    logic        slt_bit;
    logic [31:0] result_next;
    logic        zero_next;
    logic [31:0] branch_next;

    assign funct     = sign_ext_imm[5:0];
    assign shamt     = sign_ext_imm[10:6];
    assign operand_b = alu_src ? sign_ext_imm : reg_data2;
    assign add_sum   = reg_data1 + operand_b;
    assign sub_diff  = reg_data1 - operand_b;
    assign slt_bit   = ($signed(reg_data1) < $signed(operand_b));

    // ALU control decode: ALUop selects the operation, funct refines R-type
    always_comb begin
        alu_ctl = CTL_ADD;
        case (alu_op)
            3'b000: alu_ctl = CTL_ADD;
            3'b001: alu_ctl = CTL_SUB;
            3'b010: begin
                case (funct)
                    6'b100000: alu_ctl = CTL_ADD;
                    6'b100010: alu_ctl = CTL_SUB;
                    6'b100100: alu_ctl = CTL_AND;
                    6'b100101: alu_ctl = CTL_OR;
                    6'b100111: alu_ctl = CTL_NOR;
                    6'b101010: alu_ctl = CTL_SLT;
                    6'b000000: alu_ctl = CTL_SLL;
                    6'b000010: alu_ctl = CTL_SRL;
                    default:   alu_ctl = CTL_ADD;
                endcase
            end
            3'b011: alu_ctl = CTL_AND;
            3'b100: alu_ctl = CTL_OR;
            3'b101: alu_ctl = CTL_SLT;
            default: alu_ctl = CTL_ADD;   // 110 (addi) and 111
        endcase
    end

    // ALU datapath: shifts act on rt directly, operand A is ignored for them
    always_comb begin
        result_next = add_sum;
        case (alu_ctl)
            CTL_ADD: result_next = add_sum;
            CTL_SUB: result_next = sub_diff;
            CTL_AND: result_next = reg_data1 & operand_b;
            CTL_OR:  result_next = reg_data1 | operand_b;
            CTL_NOR: result_next = ~(reg_data1 | operand_b);
            CTL_SLT: result_next = {31'b0, slt_bit};
            CTL_SLL: result_next = reg_data2 << shamt;
            CTL_SRL: result_next = reg_data2 >> shamt;
            default: result_next = add_sum;
        endcase
    end

    assign zero_next   = (result_next == 32'd0);
    // Immediate << 2 drops its two top bits; the sum wraps modulo 2^32
    assign branch_next = incremented_pc + {sign_ext_imm[29:0], 2'b00};

    // EX/MEM result registers; reset forces zero_flag low so no branch fires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result     <= 32'd0;
            zero_flag      <= 1'b0;
            branch_address <= 32'd0;
        end else begin
            alu_result     <= result_next;
            zero_flag      <= zero_next;
            branch_address <= branch_next;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic overflow_next;

    // Signed overflow: ADD of like-signed or SUB of unlike-signed operands
    // producing a result whose sign differs from operand A
    always_comb begin
        overflow_next = 1'b0;
        case (alu_ctl)
            CTL_ADD: overflow_next = (reg_data1[31] == operand_b[31]) &&
                                     (add_sum[31] != reg_data1[31]);
            CTL_SUB: overflow_next = (reg_data1[31] != operand_b[31]) &&
                                     (sub_diff[31] != reg_data1[31]);
            default: overflow_next = 1'b0;
        endcase
    end

    // Overflow flag registered alongside the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan cases plus
// randomized operations against a behavioural reference model.
// Optional feature macro: ALU_OVERFLOW_EN (overflow port checked when defined).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  alu_op = 3'd0;
    logic        alu_src = 1'b0;
    logic [31:0] reg_data1 = 32'd0;
    logic [31:0] reg_data2 = 32'd0;
    logic [31:0] sign_ext_imm = 32'd0;
    logic [31:0] incremented_pc = 32'd0;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic [31:0] branch_address;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] prev_res = 32'd0;
    logic        have_prev = 1'b0;

    alu_exec_unit dut (
        .clk            (clk),
        .reset          (reset),
        .alu_op         (alu_op),
        .alu_src        (alu_src),
        .reg_data1      (reg_data1),
        .reg_data2      (reg_data2),
        .sign_ext_imm   (sign_ext_imm),
        .incremented_pc (incremented_pc),
        .alu_result     (alu_result),
        .zero_flag      (zero_flag),
`ifdef ALU_OVERFLOW_EN
        .overflow       (overflow),
`endif
        .branch_address (branch_address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: works from the operation tables with wide signed
    // arithmetic rather than sign-bit tricks.
    function automatic void model(input logic [2:0] op, input logic src,
                                  input logic [31:0] a, input logic [31:0] rt,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  output logic [31:0] res, output logic ov,
                                  output logic [31:0] br);
        logic [31:0] b;
        longint sa, sb, s;
        string kind;
        b  = src ? imm : rt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: kind = "sub";
            3'd3: kind = "and";
            3'd4: kind = "or";
            3'd5: kind = "slt";
            3'd2: begin
                case (imm[5:0])
                    6'd32: kind = "add";
                    6'd34: kind = "sub";
                    6'd36: kind = "and";
                    6'd37: kind = "or";
                    6'd39: kind = "nor";
                    6'd42: kind = "slt";
                    6'd0:  kind = "sll";
                    6'd2:  kind = "srl";
                    default: kind = "add";
                endcase
            end
            default: kind = "add";
        endcase
        ov = 1'b0;
        s  = 0;
        if (kind == "add") s = sa + sb;
        if (kind == "sub") s = sa - sb;
        if (kind == "add" || kind == "sub") begin
            res = s[31:0];
            ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (kind == "and") res = a & b;
        else if (kind == "or")  res = a | b;
        else if (kind == "nor") res = ~(a | b);
        else if (kind == "slt") res = (sa < sb) ? 32'd1 : 32'd0;
        else if (kind == "sll") res = rt * (32'd1 << imm[10:6]);
        else                    res = rt / (32'd1 << imm[10:6]);
        br = 32'((64'(pc) + 64'(imm) * 4) % 64'h1_0000_0000);
    endfunction

    // One operation: drive inputs, confirm the outputs still hold the previous
    // result before the edge, then check the new result one edge later.
    task automatic apply(input string tag, input logic [2:0] op, input logic src,
                         input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic use_const, input logic [31:0] exp_const);
        logic [31:0] er, eb;
        logic        eo;
        alu_op = op; alu_src = src; reg_data1 = a; reg_data2 = rt;
        sign_ext_imm = imm; incremented_pc = pc;
        model(op, src, a, rt, imm, pc, er, eo, eb);
        #1;
        if (have_prev) check({tag, "_hold"}, alu_result, prev_res);
        @(posedge clk);
        #1;
        check({tag, "_result"}, alu_result, er);
        check({tag, "_zero"}, {31'd0, zero_flag}, {31'd0, (er == 32'd0)});
        check({tag, "_branch"}, branch_address, eb);
`ifdef ALU_OVERFLOW_EN
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
`endif
        if (use_const) check({tag, "_const"}, alu_result, exp_const);
        prev_res  = er;
        have_prev = 1'b1;
        $display("txn %s op=%0d src=%0d a=%h rt=%h imm=%h pc=%h -> res=%h z=%0d br=%h",
                 tag, op, src, a, rt, imm, pc, alu_result, zero_flag, branch_address);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"}, alu_result, 32'd0);
        check({tag, "_zero"}, {31'd0, zero_flag}, 32'd0);
        check({tag, "_branch"}, branch_address, 32'd0);
`ifdef ALU_OVERFLOW_EN
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
`endif
    endtask

    logic [5:0] functs [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2};

    initial begin
        // Load a nonzero result, then reset asynchronously mid-cycle
        apply("pre", 3'd0, 1'b0, 32'd5, 32'd7, 32'd3, 32'd100, 1'b1, 32'd12);
        reset = 1'b1;
        #1;
        check_cleared("rst_async");
        @(posedge clk);
        #1;
        check_cleared("rst_hold");
        reset = 1'b0;
        prev_res = 32'd0;
        apply("post_rst", 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 32'd12);

        // beq comparisons
        apply("beq_eq", 3'd1, 1'b0, 32'h1234, 32'h1234, 32'd8, 32'd64, 1'b1, 32'd0);
        apply("beq_ne", 3'd1, 1'b0, 32'd3, 32'd4, 32'd8, 32'd64, 1'b1, 32'hFFFFFFFF);

        // R-type sweep
        apply("r_and", 3'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h24, 32'd0, 1'b1, 32'h00F000F0);
        apply("r_or",  3'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h25, 32'd0, 1'b1, 32'hFFF0FFF0);
        apply("r_nor", 3'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h27, 32'd0, 1'b1, 32'h000F000F);
        apply("r_slt", 3'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h2A, 32'd0, 1'b1, 32'd1);
        apply("r_sll", 3'd2, 1'b0, 32'hF0F0F0F0, 32'd1, 32'h7C0, 32'd0, 1'b1, 32'h80000000);
        apply("r_srl", 3'd2, 1'b0, 32'hF0F0F0F0, 32'd1, 32'h7C2, 32'd0, 1'b1, 32'd0);

        // Immediate path and branch adder in the same cycle
        apply("addi", 3'd6, 1'b1, 32'd10, 32'd99, 32'hFFFFFFFC, 32'd40, 1'b1, 32'd6);
        check("addi_branch_const", branch_address, 32'd24);

        // Wrap, overflow and branch wrap
        apply("wrap", 3'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFC, 1'b1, 32'h80000000);
        check("wrap_branch_const", branch_address, 32'd0);
`ifdef ALU_OVERFLOW_EN
        check("wrap_overflow_const", {31'd0, overflow}, 32'd1);
`endif

        // Back-to-back random operations, one per cycle
        for (int i = 0; i < 120; i++) begin
            logic [2:0]  op;
            logic [31:0] a, rt, imm;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            rt  = $urandom;
            imm = $urandom;
            if (op == 3'd2 && $urandom_range(0, 3) != 0)
                imm[5:0] = functs[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) rt = a;
            if ($urandom_range(0, 7) == 0) imm = a;
            apply("rand", op, 1'($urandom_range(0, 1)), a, rt, imm, $urandom, 1'b0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block of the 5-stage MIPS pipeline. It combines ALU control decoding, the 32-bit ALU with its operand-B select, and the branch-target adder. All results are registered into the EX/MEM boundary one cycle after their operands are presented. The decode stage feeds ALUop and operands; the memory stage consumes `alu_result`, `zero_flag` and `branch_address`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all outputs
- `alu_op`  in  3  ALUop from main control
- `alu_src`  in  1  0: operand B = `reg_data2`; 1: operand B = `sign_ext_imm`
- `reg_data1`  in  32  operand A (rs)
- `reg_data2`  in  32  rt register value
- `sign_ext_imm`  in  32  sign-extended immediate; bits [5:0] = funct, [10:6] = shamt
- `incremented_pc`  in  32  PC+4 of the instruction
- `alu_result`  out  32  registered ALU result
- `zero_flag`  out  1  registered, 1 when the computed result is 0
- `branch_address`  out  32  registered `incremented_pc + (sign_ext_imm << 2)`
- `overflow`  out  1  only with `ALU_OVERFLOW_EN`; see Configuration

## Operation
- ALUop decode to internal 3-bit ALU control:
  - 000 ADD (lw/sw)
  - 001 SUB (beq)
  - 010 R-type, use funct
  - 011 AND
  - 100 OR
  - 101 SLT
  - 110 ADD (addi)
  - 111 ADD
- Funct decode when ALUop = 010:
  - 100000 ADD
  - 100010 SUB
  - 100100 AND
  - 100101 OR
  - 100111 NOR
  - 101010 SLT
  - 000000 SLL
  - 000010 SRL
  - any other funct: ADD.
- Operations, with A = `reg_data1` and B = mux output:
  - ADD/SUB: modulo 2^32, wrap silently.
  - AND, OR, NOR: bitwise.
  - SLT: signed compare, result is 1 if A < B, else 0.
  - SLL/SRL: shift `reg_data2` by shamt `sign_ext_imm[10:6]`, zero fill. A is ignored.
- `zero_flag` = (result == 0), computed on the same result that is registered.
- Branch adder: immediate shifted left 2 (upper bits discarded), added modulo 2^32 to `incremented_pc`. It computes every cycle regardless of ALUop.

## Timing
- All outputs are flops, updated on posedge `clk`. Latency is 1 cycle from inputs to outputs. No handshake; a new operation is accepted every cycle.
- `reset` high: `alu_result` = 0, `branch_address` = 0, `zero_flag` = 0 (deliberately not 1, so no spurious branch). `overflow` = 0.
- Reset asserted mid-stream clears outputs immediately, without waiting for a clock edge.
- The first edge after deassertion registers the current inputs.
- X/undefined inputs are not sanitised; the bench drives defined values.

## Configuration
- `ALU_OVERFLOW_EN` defined:
  - `overflow` port exists.
  - Registered signed overflow for ADD/SUB: operands of the same sign (ADD) or opposite sign (SUB) give a result of differing sign.
  - 0 for all other operations.
  - The result still wraps.
- Undefined: the port is absent and the logic is removed; all other behaviour is identical.

## Test plan
- Reset while inputs are active:
  - Assert `reset` → all outputs 0 and `zero_flag` 0 asynchronously.
  - After release, ALUop 000, A=5, B(reg)=7, `alu_src`=0 → next edge `alu_result`=12, `zero_flag`=0.
- beq compare, ALUop 001:
  - A=B=0x1234 → `zero_flag`=1, result 0.
  - A=3, B=4 → result 0xFFFFFFFF, `zero_flag`=0.
- R-type sweep, ALUop 010, A=0xF0F0F0F0, rt=0x0FF00FF0:
  - funct 100100 → 0x00F000F0
  - funct 100101 → 0xFFF0FFF0
  - funct 100111 → 0x000F000F
  - funct 101010 → 1 (A negative)
  - SLL with rt=1, shamt 31 → 0x80000000
  - SRL with rt=1, shamt 31 → 0
- Immediate path: ALUop 110, `alu_src`=1, A=10, imm=0xFFFFFFFC → result 6. Branch adder in the same cycle: `incremented_pc`=40, imm=0xFFFFFFFC → `branch_address`=24.
- Wrap and overflow: ADD 0x7FFFFFFF+1 → 0x80000000; `overflow`=1 when `ALU_OVERFLOW_EN` is defined. Branch `incremented_pc`=0xFFFFFFFC, imm=1 → `branch_address`=0.
- Back-to-back: a new operation every cycle for 8 cycles → each result appears exactly one edge after its inputs, with no bubbles.
